// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed from latched operands and committed only on the final Busy cycle.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  XALUOp,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q, hi_nx, lo_nx;
  logic        load;

  logic        sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Bit 0 of the op selects unsigned for both MULT/MULTU and DIV/DIVU.
  always_comb begin
    sgn   = ~op_q[0];
    a_ext = {{32{sgn & a_q[31]}}, a_q};
    b_ext = {{32{sgn & b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
    a_neg = sgn & a_q[31];
    b_neg = sgn & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          unique case (XALUOp)
            3'd0, 3'd1: begin
              load     = 1'b1;
              cnt_nx   = MULT_CYCLES;
              state_nx = RUN;
            end
            3'd2, 3'd3: begin
              load     = 1'b1;
              cnt_nx   = DIV_CYCLES;
              state_nx = RUN;
            end
            3'd4:    hi_nx = RD1;
            3'd5:    lo_nx = RD1;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 32'd1;
        if (cnt == 32'd1) begin
          state_nx = IDLE;
          if (!op_q[1]) begin
            hi_nx = prod[63:32];
            lo_nx = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_nx = rem;
            lo_nx = quo;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      if (load) begin
        op_q <= XALUOp[1:0];
        a_q  <= RD1;
        b_q  <= RD2;
      end
    end
  end

  assign Busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  XALUOp = '0;
  logic [31:0] RD1 = '0;
  logic [31:0] RD2 = '0;
  logic        Busy;
  logic [31:0] HI, LO;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .XALUOp(XALUOp),
    .RD1(RD1), .RD2(RD2), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed at issue with 64-bit arithmetic, held until
  // the busy window expires.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_valid = 1'b0;

  always @(posedge Clock) begin
    longint      sa, sb;
    logic [63:0] pr;
    if (!Reset) begin
      m_rem = 0; m_hi = '0; m_lo = '0; p_valid = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_valid) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (Start) begin
      sa = longint'($signed(RD1));
      sb = longint'($signed(RD2));
      case (XALUOp)
        3'd0: begin pr = 64'(sa * sb); {p_hi, p_lo} = pr; p_valid = 1'b1; m_rem = MC; end
        3'd1: begin pr = {32'd0, RD1} * {32'd0, RD2}; {p_hi, p_lo} = pr; p_valid = 1'b1; m_rem = MC; end
        3'd2: begin
          p_valid = (RD2 != 0);
          if (p_valid) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
          m_rem = DC;
        end
        3'd3: begin
          p_valid = (RD2 != 0);
          if (p_valid) begin p_lo = RD1 / RD2; p_hi = RD1 % RD2; end
          m_rem = DC;
        end
        3'd4: m_hi = RD1;
        3'd5: m_lo = RD1;
        default: ;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("busy", {31'd0, Busy}, {31'd0, m_rem > 0});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; XALUOp = op; RD1 = a; RD2 = b;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge Clock); #1;
    issue_now(op, a, b);
  endtask

  // Counts Busy cycles from now; returns at the negedge of the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (!Busy) break;
      n++;
    end
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge Clock);
    #1; chk_en = 1'b1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    Reset = 1'b1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi_during", HI, 32'd0);
    wait_idle(n);
    check("mult_cycles", n, MC);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, MC);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, DC);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue_now(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("divu_b2b_cycles", n, DC);
    check("divu_lo", LO, 32'h7FFF_FFFC);
    check("divu_hi", HI, 32'h0000_0001);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    issue_now(3'd5, 32'hCAFE_BABE, 32'd0);
    check("mtlo_lo", LO, 32'hCAFE_BABE);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    check("div0_cycles", n, DC);
    check("div0_hi", HI, 32'h1234_5678);
    check("div0_lo", LO, 32'hCAFE_BABE);

    issue(3'd0, 32'd100, 32'd100);
    @(posedge Clock); #1;
    issue_now(3'd5, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    check("mult_ign_cycles", n + 2, MC);
    check("mult_ign_hi", HI, 32'h0);
    check("mult_ign_lo", LO, 32'h0000_2710);

    issue(3'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge Clock); #1; end
    Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (15) @(posedge Clock);
    #1;
    check("abort_nocommit_lo", LO, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    check("post_reset_lo", LO, 32'd12);
    check("post_reset_hi", HI, 32'd0);

    for (int c = 0; c < 2000; c++) begin
      @(posedge Clock); #1;
      Reset  = ($urandom_range(0, 150) != 0);
      Start  = ($urandom_range(0, 2) == 0);
      XALUOp = 3'($urandom_range(0, 7));
      RD1    = pick32();
      RD2    = pick32();
    end
    @(posedge Clock); #1;
    Start = 1'b0; Reset = 1'b1;
    repeat (DC + 2) @(posedge Clock);
    @(negedge Clock);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide responder that sits in the EX stage beside the ALU and owns the architectural HI/LO registers.
- The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO with a one-cycle Start and operands from the forwarded rs/rt values.
- The unit raises Busy while an operation is in flight.
- The hazard controller stalls any HI/LO user in D while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for MULT/MULTU (must be at least 1).
- DIV_CYCLES, 10, number of Busy cycles for DIV/DIVU (must be at least 1).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous reset, active-low: 0 at a rising edge resets the unit.
- Start  in  1  one-cycle request; qualifies XALUOp, RD1 and RD2.
- XALUOp  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- RD1  in  32  rs operand (dividend / multiplicand / MT source).
- RD2  in  32  rt operand (divisor / multiplier).
- Busy  out  1  operation in flight.
- HI  out  32  committed HI register.
- LO  out  32  committed LO register.

Behaviour:
- Reset (Reset=0 at an edge):
  - Busy=0, HI=0, LO=0, cycle counter=0, pending result cleared.
  - Any in-flight operation is discarded.
  - Reset has priority over Start.
- States are IDLE and RUN. Busy=1 exactly when the state is RUN. Busy is registered.
- IDLE, Start=1, op in 0..3, sampled at the edge ending cycle T:
  - Latch RD1, RD2 and the op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN.
  - Busy=1 during cycles T+1 .. T+N.
- RUN:
  - The counter decrements each edge.
  - At the edge ending cycle T+N: commit the result to HI/LO, set Busy=0, return to IDLE.
  - The new HI/LO values are visible from cycle T+N+1, the same cycle Busy reads 0.
- HI/LO never show partial or intermediate values. Internal iterative or one-shot computation is free, provided only the committed result is visible.
- MULT: signed 32x32 to 64 bits; HI=product[63:32], LO=product[31:0].
- MULTU: same as MULT, with both operands unsigned.
- DIV (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divisor = 0 (DIV or DIVU): Busy runs the full DIV_CYCLES, then HI/LO are left unchanged.
- MTHI/MTLO with Start=1 in IDLE:
  - Write RD1 into HI or LO at that edge; no Busy.
  - Visible in cycle T+1.
- Start=1 while in RUN: ignored entirely, for every op including MTHI/MTLO. The hazard controller guarantees this never happens; the unit still tolerates it.
- Start=1 with XALUOp=6 or 7: no effect.
- Start=1 in the cycle Busy falls (state IDLE at that edge): accepted normally. Back-to-back operations are therefore possible with zero idle gap.
- Reset asserted mid-RUN:
  - Operation aborted, HI/LO=0 at the next cycle.
  - An operation started after reset deasserts behaves normally.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1, then MULT with RD1=0xFFFFFFFD (-3) and RD2=7:
  - Busy is high exactly 5 cycles.
  - Next cycle: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - HI/LO stay 0 during Busy.
- MULTU with 0xFFFFFFFF and 2: after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV:
  - 0xFFFFFFF9 (-7) / 2: after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU 0xFFFFFFF9 / 2, issued in the cycle Busy falls: LO=0x7FFFFFFC, HI=0x00000001.
- MTHI 0x12345678, then MTLO 0xCAFEBABE on consecutive cycles:
  - Busy stays 0; HI and LO update one cycle after each Start.
  - Then DIV by 0: Busy for 10 cycles; HI/LO still 0x12345678 / 0xCAFEBABE.
- MULT 100*100 started, then Start=1 with MTLO 0xDEADBEEF during cycle 2 of Busy:
  - The MTLO is ignored.
  - Final HI=0, LO=0x00002710, with Busy still exactly 5 cycles.
- DIVU started, then Reset=0 during Busy cycle 4:
  - Next cycle Busy=0, HI=LO=0, and no later commit occurs.
  - Afterwards MULTU 3*4 gives LO=12, HI=0.
